// File: rtl/audio_path_pkg.sv
// Shared types and constants for the audio sample path controller.
package audio_path_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ROM_WAIT = 2'd1,
      FILT     = 2'd2,
      PUSH     = 2'd3
   } audio_state_t;

   localparam int AP_DATA_W       = 24;
   localparam int AP_FILT_LOG2    = 3;
   localparam int AP_DROP_TIMEOUT = 1024;

endpackage

// File: rtl/moving_avg.sv
// One channel of the moving-average filter: tap history, running sum and
// the arithmetic divide by 2**FILT_LOG2 of the post-update sum.
module moving_avg #(
   parameter int DATA_W    = 24,
   parameter int FILT_LOG2 = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_sample,
   output logic [DATA_W-1:0] o_avg
);

   localparam int N  = 2**FILT_LOG2;
   localparam int SW = DATA_W + FILT_LOG2;

   logic [N-1:0][DATA_W-1:0] r_hist;
   logic [SW-1:0]            r_sum;
   logic [SW-1:0]            w_new;
   logic [SW-1:0]            w_old;
   logic [SW-1:0]            w_sum_nxt;

   assign w_new     = {{FILT_LOG2{i_sample[DATA_W-1]}}, i_sample};
   assign w_old     = {{FILT_LOG2{r_hist[N-1][DATA_W-1]}}, r_hist[N-1]};
   assign w_sum_nxt = r_sum + w_new - w_old;
   // Top DATA_W bits of the sum are the sum >>> FILT_LOG2 (floor division).
   assign o_avg     = w_sum_nxt[SW-1 -: DATA_W];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hist <= '0;
         r_sum  <= '0;
      end else if (i_clr) begin
         r_hist <= '0;
         r_sum  <= '0;
      end else if (i_en) begin
         r_hist <= {r_hist[N-2:0], i_sample};
         r_sum  <= w_sum_nxt;
      end
   end

endmodule

// File: rtl/audio_path_ctrl.sv
// Sequences ADC pop -> (tone ROM) -> moving-average filter -> DAC push.
// Optional build macro AUDIO_PATH_CTRL_DROP_EN adds a PUSH timeout and drop_count.
module audio_path_ctrl
   import audio_path_pkg::*;
#(
   parameter int DATA_W    = AP_DATA_W,
   parameter int ROM_DEPTH = 48,
   parameter int FILT_LOG2 = AP_FILT_LOG2
) (
   input  logic                         CLOCK_50,
   input  logic                         reset_n,
   input  logic                         mode_sel,
   input  logic                         filter_en,
   input  logic                         read_ready,
   output logic                         read,
   input  logic [DATA_W-1:0]            readdata_left,
   input  logic [DATA_W-1:0]            readdata_right,
   input  logic                         write_ready,
   output logic                         write,
   output logic [DATA_W-1:0]            writedata_left,
   output logic [DATA_W-1:0]            writedata_right,
   output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
   input  logic [DATA_W-1:0]            rom_data,
   output logic                         busy
`ifdef AUDIO_PATH_CTRL_DROP_EN
   ,
   output logic [7:0]                   drop_count
`endif
);

   localparam int AW = $clog2(ROM_DEPTH);

   audio_state_t     r_state, w_state_nxt;
   logic             r_mode, r_filt;
   logic [DATA_W-1:0] r_raw_l, r_raw_r;
   logic [DATA_W-1:0] r_wd_l, r_wd_r;
   logic [AW-1:0]    r_rom_addr;
   logic [DATA_W-1:0] w_samp_l, w_samp_r, w_avg_l, w_avg_r;
   logic             w_clr, w_upd, w_timeout;

   assign w_clr    = read && (mode_sel != r_mode);
   assign w_upd    = (r_state == FILT);
   assign w_samp_l = r_mode ? rom_data : r_raw_l;
   assign w_samp_r = r_mode ? rom_data : r_raw_r;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (read_ready) w_state_nxt = mode_sel ? ROM_WAIT : FILT;
         ROM_WAIT: w_state_nxt = FILT;
         FILT:     w_state_nxt = PUSH;
         PUSH:     if (write_ready || w_timeout) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // read is gated by reset_n so every output is low while reset is held.
   always_comb begin
      read  = 1'b0;
      write = 1'b0;
      busy  = (r_state != IDLE);
      case (r_state)
         IDLE:    read  = reset_n & read_ready;
         PUSH:    write = write_ready;
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_mode     <= 1'b0;
         r_filt     <= 1'b0;
         r_raw_l    <= '0;
         r_raw_r    <= '0;
         r_wd_l     <= '0;
         r_wd_r     <= '0;
         r_rom_addr <= '0;
      end else begin
         if (read) begin
            r_raw_l <= readdata_left;
            r_raw_r <= readdata_right;
            r_mode  <= mode_sel;
            r_filt  <= filter_en;
            if (mode_sel != r_mode) r_rom_addr <= '0;
         end
         if (r_state == FILT) begin
            r_wd_l <= r_filt ? w_avg_l : w_samp_l;
            r_wd_r <= r_filt ? w_avg_r : w_samp_r;
            if (r_mode)
               r_rom_addr <= (r_rom_addr == AW'(ROM_DEPTH-1)) ? '0 : r_rom_addr + AW'(1);
         end
      end
   end

   assign writedata_left  = r_wd_l;
   assign writedata_right = r_wd_r;
   assign rom_addr        = r_rom_addr;

`ifdef AUDIO_PATH_CTRL_DROP_EN
   localparam int WW = $clog2(AP_DROP_TIMEOUT);

   logic [WW-1:0] r_wait;
   logic [7:0]    r_drop;

   assign w_timeout = (r_state == PUSH) && !write_ready && (r_wait == WW'(AP_DROP_TIMEOUT-1));

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_wait <= '0;
         r_drop <= '0;
      end else begin
         r_wait <= (r_state == PUSH) ? r_wait + WW'(1) : '0;
         if (w_timeout && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
   end

   assign drop_count = r_drop;
`else
   assign w_timeout = 1'b0;
`endif

   moving_avg #(.DATA_W(DATA_W), .FILT_LOG2(FILT_LOG2)) u_avg_l (
      .i_clk(CLOCK_50), .i_rst_n(reset_n), .i_clr(w_clr), .i_en(w_upd),
      .i_sample(w_samp_l), .o_avg(w_avg_l)
   );

   moving_avg #(.DATA_W(DATA_W), .FILT_LOG2(FILT_LOG2)) u_avg_r (
      .i_clk(CLOCK_50), .i_rst_n(reset_n), .i_clr(w_clr), .i_en(w_upd),
      .i_sample(w_samp_r), .o_avg(w_avg_r)
   );

endmodule

// File: tb/tb_audio_path_ctrl.sv
// Randomized bench for audio_path_ctrl against a transaction-level model.
module tb_audio_path_ctrl;

   localparam int DW = 24;
   localparam int RD = 48;
   localparam int N  = 8;

   logic          CLOCK_50 = 1'b0;
   logic          reset_n = 1'b0;
   logic          mode_sel = 1'b0, filter_en = 1'b0;
   logic          read_ready = 1'b0, write_ready = 1'b0;
   logic          read, write, busy;
   logic [DW-1:0] readdata_left = '0, readdata_right = '0;
   logic [DW-1:0] writedata_left, writedata_right;
   logic [DW-1:0] rom_data = '0;
   logic [5:0]    rom_addr;
`ifdef AUDIO_PATH_CTRL_DROP_EN
   logic [7:0]    drop_count;
`endif

   int            n_chk = 0;
   int            n_err = 0;
   logic [DW-1:0] rom_tbl [RD];

   // model state: last mode, ROM pointer, last N samples per channel
   bit            m_mode;
   int            m_addr;
   longint        h_l[$], h_r[$];

   audio_path_ctrl dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .mode_sel(mode_sel), .filter_en(filter_en),
      .read_ready(read_ready), .read(read),
      .readdata_left(readdata_left), .readdata_right(readdata_right),
      .write_ready(write_ready), .write(write),
      .writedata_left(writedata_left), .writedata_right(writedata_right),
      .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
`ifdef AUDIO_PATH_CTRL_DROP_EN
      , .drop_count(drop_count)
`endif
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) rom_data <= (int'(rom_addr) < RD) ? rom_tbl[rom_addr] : '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 1'b0;
      m_addr = 0;
      h_l = {};
      h_r = {};
      for (int i = 0; i < N; i++) begin
         h_l.push_back(0);
         h_r.push_back(0);
      end
   endtask

   function automatic longint floor_div(input longint s);
      if (s >= 0) return s / N;
      return -((-s + N - 1) / N);
   endfunction

   task automatic model_step(input bit m, input bit f, input logic [DW-1:0] l, input logic [DW-1:0] r,
                             output logic [DW-1:0] el, output logic [DW-1:0] er);
      logic [DW-1:0] sl, sr;
      longint        tl, tr;
      if (m != m_mode) begin
         model_reset();
         m_mode = m;
      end
      if (m) begin
         sl = rom_tbl[m_addr];
         sr = sl;
         m_addr = (m_addr + 1) % RD;
      end else begin
         sl = l;
         sr = r;
      end
      h_l.push_back(longint'($signed(sl)));
      h_r.push_back(longint'($signed(sr)));
      void'(h_l.pop_front());
      void'(h_r.pop_front());
      tl = 0;
      tr = 0;
      foreach (h_l[i]) tl += h_l[i];
      foreach (h_r[i]) tr += h_r[i];
      el = f ? DW'(floor_div(tl)) : sl;
      er = f ? DW'(floor_div(tr)) : sr;
   endtask

   // One sample end to end; called and returns just after a negedge in IDLE.
   task automatic xact(input bit m, input bit f, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input int stall);
      logic [DW-1:0] el, er;
      int            lat, exp_k, k, n_rd;
      bit            seen;
      model_step(m, f, l, r, el, er);
      lat   = m ? 3 : 2;
      exp_k = (stall > lat) ? stall : lat;
      mode_sel = m; filter_en = f;
      readdata_left = l; readdata_right = r;
      read_ready = 1'b1;
      write_ready = (stall == 0);
      #1 chk("read_pop", 32'(read), 32'd1);
      @(posedge CLOCK_50); #1;
      // later switch changes and FIFO contents must not touch the in-flight sample
      mode_sel = ~m; filter_en = ~f;
      readdata_left = DW'($urandom); readdata_right = DW'($urandom);
      seen = 1'b0; n_rd = 0; k = 0;
      while (!seen && k < stall + 8) begin
         k++;
         @(negedge CLOCK_50);
         write_ready = (k >= stall);
         #1;
         n_rd += int'(read);
         if (write) begin
            seen = 1'b1;
            chk("write_latency", 32'(k), 32'(exp_k));
            chk("wdata_left", 32'(writedata_left), 32'(el));
            chk("wdata_right", 32'(writedata_right), 32'(er));
            chk("busy_push", 32'(busy), 32'd1);
            read_ready = 1'b0;
         end
      end
      chk("write_seen", 32'(seen), 32'd1);
      chk("no_read_outside_idle", 32'(n_rd), 32'd0);
      @(negedge CLOCK_50); #1;
      chk("busy_idle", 32'(busy), 32'd0);
      chk("wdata_hold", 32'(writedata_left), 32'(el));
   endtask

   task automatic reset_in_filt();
      mode_sel = 1'b0; filter_en = 1'b1;
      readdata_left = DW'($urandom); readdata_right = DW'($urandom);
      read_ready = 1'b1; write_ready = 1'b1;
      @(posedge CLOCK_50); #1;
      chk("in_filt_busy", 32'(busy), 32'd1);
      #3 reset_n = 1'b0;
      #1;
      chk("rst_read", 32'(read), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wd_l", 32'(writedata_left), 32'd0);
      chk("rst_wd_r", 32'(writedata_right), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      read_ready = 1'b0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      model_reset();
      #1;
   endtask

`ifdef AUDIO_PATH_CTRL_DROP_EN
   task automatic drop_test();
      logic [DW-1:0] el, er;
      int            n_wr;
      model_step(1'b0, 1'b0, 24'h000777, 24'h000888, el, er);
      mode_sel = 1'b0; filter_en = 1'b0;
      readdata_left = 24'h000777; readdata_right = 24'h000888;
      read_ready = 1'b1; write_ready = 1'b0;
      @(posedge CLOCK_50); #1;
      read_ready = 1'b0;
      n_wr = 0;
      repeat (1100) begin
         @(negedge CLOCK_50); #1;
         n_wr += int'(write);
      end
      chk("drop_no_write", 32'(n_wr), 32'd0);
      chk("drop_count", 32'(drop_count), 32'd1);
      chk("drop_idle", 32'(busy), 32'd0);
      write_ready = 1'b1;
   endtask
`endif

   initial begin
      for (int i = 0; i < RD; i++) rom_tbl[i] = DW'($urandom);
      model_reset();
      read_ready = 1'b1;
      #25;
      chk("reset_read", 32'(read), 32'd0);
      chk("reset_write", 32'(write), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_wd_l", 32'(writedata_left), 32'd0);
      chk("reset_wd_r", 32'(writedata_right), 32'd0);
      chk("reset_rom_addr", 32'(rom_addr), 32'd0);
`ifdef AUDIO_PATH_CTRL_DROP_EN
      chk("reset_drop_count", 32'(drop_count), 32'd0);
`endif
      read_ready = 1'b0;
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      #1;

      xact(1'b0, 1'b0, 24'h000123, 24'hFFFFF0, 0);
      chk("pass_left", 32'(writedata_left), 32'h000123);
      chk("pass_right", 32'(writedata_right), 32'hFFFFF0);

      reset_in_filt();

      for (int i = 0; i < N; i++) begin
         xact(1'b0, 1'b1, 24'd800, DW'($urandom), 0);
         chk("avg_ramp", 32'(writedata_left), 32'(100 * (i + 1)));
      end
      xact(1'b0, 1'b1, DW'(-800), DW'($urandom), 0);
      chk("avg_after_neg", 32'(writedata_left), 32'd600);

      for (int i = 0; i <= RD; i++) xact(1'b1, 1'b0, DW'($urandom), DW'($urandom), 0);
      chk("rom_wrap_last", 32'(writedata_left), 32'(rom_tbl[0]));

      for (int i = 0; i < 3; i++) xact(1'b0, 1'b1, DW'($urandom), DW'($urandom), 0);
      xact(1'b1, 1'b0, DW'($urandom), DW'($urandom), 0);
      chk("rom_restart", 32'(writedata_left), 32'(rom_tbl[0]));

      for (int i = 0; i < 40; i++)
         xact(($urandom_range(0, 3) == 0), 1'($urandom), DW'($urandom), DW'($urandom),
              $urandom_range(0, 4));

      xact(1'b0, 1'b0, DW'($urandom), DW'($urandom), 500);

`ifdef AUDIO_PATH_CTRL_DROP_EN
      drop_test();
      xact(1'b0, 1'b1, DW'($urandom), DW'($urandom), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
